// File: rtl/snd_pkg.sv
// Shared constants, status bit layout and interrupt FSM encoding for the
// sound-side command interface.
package snd_pkg;

  localparam logic [7:0] SND_IO_DATA  = 8'h00;
  localparam logic [7:0] SND_IO_STAT  = 8'h01;
  localparam logic [7:0] SND_IO_FLUSH = 8'h02;

  localparam int STAT_NEMPTY = 0;
  localparam int STAT_FULL   = 1;
  localparam int STAT_TMR    = 2;
  localparam int STAT_OVF    = 3;

  typedef enum logic [1:0] {
    INT_IDLE   = 2'd0,
    INT_ASSERT = 2'd1,
    INT_GAP    = 2'd2
  } int_state_e;

  function automatic logic [7:0] snd_status(input logic nempty, input logic full,
                                            input logic tmr, input logic ovf);
    logic [7:0] s;
    s              = 8'h00;
    s[STAT_NEMPTY] = nempty;
    s[STAT_FULL]   = full;
    s[STAT_TMR]    = tmr;
    s[STAT_OVF]    = ovf;
    return s;
  endfunction

endpackage

// File: rtl/snd_cmd_if_fifo.sv
// Synchronous command FIFO; pointers carry one extra wrap bit so full and
// empty are distinguishable. Flush has priority over push and pop.
module snd_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  input  logic              flush,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic              push_ok;
  logic              pop_ok;

  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    head     = mem_q[rd_ptr_q[AW-1:0]];
    push_ok  = push & ~full & ~flush;
    pop_ok   = pop & ~empty & ~flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage carries data only; validity comes from the pointers.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/snd_cmd_if.sv
// Main-to-sound CPU command interface: FIFO, I/O ports 0x00-0x02, INT generator.
// Define SND_TIMER_INT_EN to add the periodic timer interrupt source.
module snd_cmd_if
  import snd_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int TIMER_DIV = 65536,
  parameter int GAP       = 2
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        main_cmd_wr,
  input  logic [7:0]  main_cmd_data,
  output logic        main_full,
  input  logic [15:0] scpu_ab,
  input  logic [7:0]  scpu_dout,
  input  logic        scpu_rd,
  input  logic        scpu_wr,
  input  logic        scpu_io,
  input  logic        scpu_m1,
  output logic        io_sel,
  output logic [7:0]  io_dout,
  output logic        scpu_int
);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);
  localparam logic [GW-1:0] GAP_ONE  = GW'(1);

  logic [7:0]    addr;
  logic          io_rd, io_wr, iack;
  logic          rd_q, rd_d, wr_q, wr_d, iack_q, iack_d;
  logic          rd_fall, wr_fall, ack;
  logic          fifo_pop, fifo_flush, stat_clr;
  logic          fifo_full, fifo_empty;
  logic [7:0]    fifo_head;
  logic [7:0]    last_q, last_d;
  logic          ovf_q, ovf_d;
  logic          io_sel_q, io_sel_d;
  logic [7:0]    io_dout_q, io_dout_d;
  logic [7:0]    status;
  logic          tmr_pend;
  int_state_e    state_q, state_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic          unused_ok;

  snd_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (8)
  ) u_fifo (
    .clk       (clk_sys),
    .rst       (reset),
    .push      (main_cmd_wr),
    .push_data (main_cmd_data),
    .pop       (fifo_pop),
    .flush     (fifo_flush),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Strobe qualification and edge detection; side effects happen on the
  // trailing edge so a read sees stable data for the whole strobe.
  always_comb begin
    addr       = scpu_ab[7:0];
    io_rd      = scpu_io & ~scpu_m1 & scpu_rd;
    io_wr      = scpu_io & ~scpu_m1 & scpu_wr;
    iack       = scpu_io & scpu_m1;
    rd_d       = io_rd;
    wr_d       = io_wr;
    iack_d     = iack;
    rd_fall    = rd_q & ~io_rd;
    wr_fall    = wr_q & ~io_wr;
    ack        = iack & ~iack_q;
    fifo_pop   = rd_fall & (addr == SND_IO_DATA);
    stat_clr   = rd_fall & (addr == SND_IO_STAT);
    fifo_flush = wr_fall & (addr == SND_IO_FLUSH);
  end

  always_comb begin
    status = snd_status(~fifo_empty, fifo_full, tmr_pend, ovf_q);
    last_d = (fifo_pop & ~fifo_empty & ~fifo_flush) ? fifo_head : last_q;
    ovf_d  = ovf_q;
    if (main_cmd_wr & fifo_full) ovf_d = 1'b1;
    else if (stat_clr)           ovf_d = 1'b0;
    io_sel_d  = io_rd & ((addr == SND_IO_DATA) | (addr == SND_IO_STAT));
    io_dout_d = 8'h00;
    if (io_rd && (addr == SND_IO_DATA))      io_dout_d = fifo_empty ? last_q : fifo_head;
    else if (io_rd && (addr == SND_IO_STAT)) io_dout_d = status;
  end

`ifdef SND_TIMER_INT_EN
  localparam int TW = (TIMER_DIV > 2) ? $clog2(TIMER_DIV) : 1;
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMER_DIV - 1);
  localparam logic [TW-1:0] TMR_ONE  = TW'(1);

  logic [TW-1:0] tmr_cnt_q, tmr_cnt_d;
  logic          tmr_tick;
  logic          tmr_pend_q, tmr_pend_d;

  // A tick coinciding with an acknowledge must not be lost.
  always_comb begin
    tmr_tick   = (tmr_cnt_q == TMR_LAST);
    tmr_cnt_d  = tmr_tick ? '0 : tmr_cnt_q + TMR_ONE;
    tmr_pend_d = tmr_pend_q;
    if (tmr_tick) tmr_pend_d = 1'b1;
    else if (ack) tmr_pend_d = 1'b0;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      tmr_cnt_q  <= '0;
      tmr_pend_q <= 1'b0;
    end else begin
      tmr_cnt_q  <= tmr_cnt_d;
      tmr_pend_q <= tmr_pend_d;
    end
  end

  assign tmr_pend  = tmr_pend_q;
  assign unused_ok = ^{scpu_dout, scpu_ab[15:8]};
`else
  assign tmr_pend  = 1'b0;
  assign unused_ok = ^{scpu_dout, scpu_ab[15:8], TIMER_DIV[0]};
`endif

  // Returning through IDLE after every acknowledge guarantees the wrapper
  // sees a fresh rising edge while work is still pending.
  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    case (state_q)
      INT_IDLE: begin
        if (~fifo_empty | tmr_pend) state_d = INT_ASSERT;
      end
      INT_ASSERT: begin
        if (ack) begin
          state_d   = INT_GAP;
          gap_cnt_d = '0;
        end
      end
      INT_GAP: begin
        if (gap_cnt_q == GAP_LAST) state_d = INT_IDLE;
        else                       gap_cnt_d = gap_cnt_q + GAP_ONE;
      end
      default: state_d = INT_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      iack_q    <= 1'b0;
      last_q    <= 8'h00;
      ovf_q     <= 1'b0;
      io_sel_q  <= 1'b0;
      io_dout_q <= 8'h00;
      state_q   <= INT_IDLE;
      gap_cnt_q <= '0;
    end else begin
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      iack_q    <= iack_d;
      last_q    <= last_d;
      ovf_q     <= ovf_d;
      io_sel_q  <= io_sel_d;
      io_dout_q <= io_dout_d;
      state_q   <= state_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  assign main_full = fifo_full;
  assign io_sel    = io_sel_q;
  assign io_dout   = io_dout_q;
  assign scpu_int  = (state_q == INT_ASSERT);

endmodule

// File: tb/tb_snd_cmd_if.sv
// Scoreboarded bench for snd_cmd_if: I/O read data checked by a monitor,
// interrupt/full timing checked inline against hand-computed cycle counts.
`timescale 1ns/1ps
module tb_snd_cmd_if;
`ifdef SND_TIMER_INT_EN
  localparam int TDIV = 100;
`else
  localparam int TDIV = 65536;
`endif

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        main_cmd_wr = 1'b0;
  logic [7:0]  main_cmd_data = 8'h00;
  logic        main_full;
  logic [15:0] scpu_ab = 16'h0000;
  logic [7:0]  scpu_dout = 8'h00;
  logic        scpu_rd = 1'b0;
  logic        scpu_wr = 1'b0;
  logic        scpu_io = 1'b0;
  logic        scpu_m1 = 1'b0;
  logic        io_sel;
  logic [7:0]  io_dout;
  logic        scpu_int;

  int          n_tests = 0;
  int          n_fail = 0;
  logic [7:0]  exp_q [$];
  logic        mon_sel_prev = 1'b0;

  snd_cmd_if #(.DEPTH(4), .TIMER_DIV(TDIV), .GAP(2)) dut (
    .clk_sys       (clk_sys),
    .reset         (reset),
    .main_cmd_wr   (main_cmd_wr),
    .main_cmd_data (main_cmd_data),
    .main_full     (main_full),
    .scpu_ab       (scpu_ab),
    .scpu_dout     (scpu_dout),
    .scpu_rd       (scpu_rd),
    .scpu_wr       (scpu_wr),
    .scpu_io       (scpu_io),
    .scpu_m1       (scpu_m1),
    .io_sel        (io_sel),
    .io_dout       (io_dout),
    .scpu_int      (scpu_int)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic push(input logic [7:0] b);
    main_cmd_wr   = 1'b1;
    main_cmd_data = b;
    cyc(1);
    main_cmd_wr   = 1'b0;
  endtask

  task automatic io_read(input logic [7:0] a, input logic [7:0] e,
                         input logic co_push, input logic [7:0] co_byte);
    exp_q.push_back(e);
    scpu_ab = {8'hA5, a};
    scpu_io = 1'b1;
    scpu_rd = 1'b1;
    cyc(4);
    scpu_io       = 1'b0;
    scpu_rd       = 1'b0;
    main_cmd_wr   = co_push;
    main_cmd_data = co_byte;
    cyc(1);
    main_cmd_wr = 1'b0;
    cyc(1);
  endtask

  task automatic io_write(input logic [7:0] a);
    scpu_ab = {8'h00, a};
    scpu_io = 1'b1;
    scpu_wr = 1'b1;
    cyc(4);
    scpu_io = 1'b0;
    scpu_wr = 1'b0;
    cyc(1);
  endtask

  task automatic iack();
    scpu_ab = 16'h0000;
    scpu_io = 1'b1;
    scpu_m1 = 1'b1;
    cyc(2);
    scpu_io = 1'b0;
    scpu_m1 = 1'b0;
    cyc(1);
  endtask

  // Monitor: each new read presentation consumes one expected byte.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk_sys);
      if (reset) begin
        mon_sel_prev = 1'b0;
      end else begin
        if (io_sel && !mon_sel_prev) begin
          if (exp_q.size() == 0) begin
            chk("sb_unexpected_sel", 32'(io_dout), 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("sb_read", 32'(io_dout), 32'(e));
          end
        end
        mon_sel_prev = io_sel;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int  hi_cnt;
    int  k;
    bit  got;
    reset = 1'b1;
    cyc(3);
    reset = 1'b0;
    chk("rst_int", scpu_int, 0);
    chk("rst_full", main_full, 0);
    chk("rst_sel", io_sel, 0);
    chk("rst_dout", io_dout, 0);

`ifdef SND_TIMER_INT_EN
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      cyc(1);
      if (scpu_int) got = 1'b1;
    end
    chk("tmr_first_rise", got, 1);
    iack();
    io_read(8'h01, 8'h00, 1'b0, 8'h00);
    got = 1'b0;
    k   = 9;
    for (int i = 0; i < 200 && !got; i++) begin
      cyc(1);
      k++;
      if (scpu_int) got = 1'b1;
    end
    chk("tmr_second_rise", got, 1);
    chk("tmr_period", k, 100);
    io_read(8'h01, 8'h04, 1'b0, 8'h00);
    iack();
    io_read(8'h01, 8'h00, 1'b0, 8'h00);
`else
    // Single push: INT latency, ack, re-arm after the gap, then silence.
    push(8'h5A);
    chk("t1_int_lat1", scpu_int, 0);
    cyc(1);
    chk("t1_int_lat2", scpu_int, 1);
    scpu_io = 1'b1;
    scpu_m1 = 1'b1;
    cyc(1);
    chk("t1_ack_fall", scpu_int, 0);
    cyc(1);
    scpu_io = 1'b0;
    scpu_m1 = 1'b0;
    chk("t1_gap_a", scpu_int, 0);
    cyc(1);
    chk("t1_gap_b", scpu_int, 0);
    cyc(1);
    chk("t1_rearm", scpu_int, 1);
    io_read(8'h00, 8'h5A, 1'b0, 8'h00);
    iack();
    cyc(10);
    chk("t1_no_edge", scpu_int, 0);

    // Overflow and drain past empty.
    push(8'h11);
    push(8'h22);
    push(8'h33);
    chk("t2_full_3", main_full, 0);
    push(8'h44);
    chk("t2_full_4", main_full, 1);
    push(8'h55);
    chk("t2_full_5", main_full, 1);
    io_read(8'h01, 8'h0B, 1'b0, 8'h00);
    io_read(8'h01, 8'h03, 1'b0, 8'h00);
    io_read(8'h00, 8'h11, 1'b0, 8'h00);
    chk("t2_full_pop", main_full, 0);
    io_read(8'h00, 8'h22, 1'b0, 8'h00);
    io_read(8'h00, 8'h33, 1'b0, 8'h00);
    io_read(8'h00, 8'h44, 1'b0, 8'h00);
    io_read(8'h00, 8'h44, 1'b0, 8'h00);
    iack();
    cyc(10);

    // Push on the pop cycle of a one-entry FIFO.
    push(8'hA1);
    cyc(2);
    io_read(8'h00, 8'hA1, 1'b1, 8'hB2);
    io_read(8'h01, 8'h01, 1'b0, 8'h00);
    io_read(8'h00, 8'hB2, 1'b0, 8'h00);
    io_read(8'h01, 8'h00, 1'b0, 8'h00);
    iack();
    cyc(10);

    // Flush.
    push(8'h01);
    push(8'h02);
    push(8'h03);
    cyc(1);
    chk("t4_int", scpu_int, 1);
    io_write(8'h02);
    io_read(8'h01, 8'h00, 1'b0, 8'h00);
    iack();
    cyc(10);
    chk("t4_int_idle", scpu_int, 0);

    // No timer: idle line stays quiet.
    hi_cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      cyc(1);
      if (scpu_int) hi_cnt++;
    end
    chk("t5_no_tmr_int", hi_cnt, 0);

    // Reset while asserting with queued bytes.
    push(8'hC1);
    push(8'hC2);
    cyc(1);
    chk("t6_int_pre", scpu_int, 1);
    reset = 1'b1;
    cyc(1);
    chk("t6_int_rst", scpu_int, 0);
    chk("t6_full_rst", main_full, 0);
    reset = 1'b0;
    cyc(10);
    chk("t6_no_edge", scpu_int, 0);
    io_read(8'h01, 8'h00, 1'b0, 8'h00);
    io_read(8'h00, 8'h00, 1'b0, 8'h00);
`endif

    cyc(2);
    chk("sb_drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
